cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
- Parametrised data-cache controller FSM for the pipelined core's MEM stage.
- Decides hit/miss handling and sequences multi-word line write-back and refill over a per-word ack handshake to main memory.
- Supports write-allocate and write-around (no-allocate) write-miss policies and keeps hit/miss performance counters.
- Datapath (tag/data arrays, muxes) is external; this block drives control only.

Parameters:
WORDS_PER_LINE, 4, words per cache line (power of 2, >=2); burst length for write-back and refill
CNT_W, $clog2(WORDS_PER_LINE), width of word index
WRITE_ALLOCATE, 1, 1 = write miss refills the line; 0 = write miss goes straight to memory, line untouched
PERF_W, 32, width of hit/miss counters

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous, active-high reset
req_read  in  1  load in MEM stage
req_write  in  1  store in MEM stage; if both requests are high, treat as write
hit  in  1  tag match and valid, from tag array
dirty  in  1  dirty bit of the indexed line
mem_ack  in  1  memory accepted or returned the current word this cycle
stall  out  1  freeze pipeline
mem_re  out  1  memory read request for word word_idx
mem_we  out  1  memory write request
wb_sel  out  1  1 = memory address/data come from the victim line; 0 = from the store
word_idx  out  CNT_W  word within line for the current burst beat
line_load  out  1  write the returned memory word into the data array at word_idx
set_valid  out  1  mark line valid (refill complete)
set_dirty  out  1  mark line dirty
clr_dirty  out  1  clear dirty bit
hit_count  out  PERF_W  hits counted
miss_count  out  PERF_W  misses counted

Behaviour:
- States: IDLE, WRITEBACK, REFILL, RESUME, WRITE_AROUND. Registered: state, cnt (CNT_W), op_wr (latched request type), hit_count, miss_count.
- All control outputs are combinational decodes of state and inputs. Each defaults to 0 in every state unless set below. word_idx equals cnt.
- Reset: state=IDLE, cnt=0, op_wr=0, both counters=0. All control outputs are 0 in the following cycle. Reset mid-burst abandons the memory transaction; no partial line is marked valid.
- IDLE, no request: stay in IDLE.
- IDLE, hit: stall=0; a write also asserts set_dirty. Stay in IDLE; hit_count increments.
- IDLE, miss (request and not hit): stall=1; op_wr<=req_write; miss_count increments. Next state:
  - write miss with WRITE_ALLOCATE=0: WRITE_AROUND, regardless of dirty.
  - otherwise, dirty: WRITEBACK.
  - otherwise: REFILL.
- WRITEBACK: stall=1, mem_we=1, wb_sel=1. On mem_ack, cnt increments. On mem_ack with cnt==WORDS_PER_LINE-1: cnt<=0, next state REFILL. Without mem_ack, hold state and cnt.
- REFILL: stall=1, mem_re=1. On mem_ack: line_load=1 and cnt increments. On the last beat also: set_valid=1, clr_dirty=1, cnt<=0, next state RESUME.
- RESUME: one cycle. stall=0, so the pipeline retires the request against the now-valid line. set_dirty=op_wr. hit is ignored here. Next state IDLE. Not counted as a hit.
- WRITE_AROUND: mem_we=1, wb_sel=0. stall=~mem_ack, so stall drops in the ack cycle. On mem_ack, next state IDLE.
- Latencies (memory acks every cycle, N=WORDS_PER_LINE):
  - clean miss stalls N+1 cycles; the request retires in the RESUME cycle.
  - dirty miss stalls 2N+1 cycles.
  - write-around stalls 1 cycle.
- cnt wraps modulo WORDS_PER_LINE. Counters saturate at all-ones and do not wrap.
- Request lines changing while state != IDLE are ignored; op_wr governs.

Decomposition:
- Package cache_pkg: cache_state_t enum (IDLE, WRITEBACK, REFILL, RESUME, WRITE_AROUND) and the policy constants ALLOC, NO_ALLOC.
- Sub-module burst_counter: CNT_W-wide counter with inc and clr inputs and a last flag (cnt==WORDS_PER_LINE-1). Instantiated once.

Test Plan:
- Read hit with req_read=1, hit=1 -> stall=0 the same cycle, hit_count 0->1, no mem_re/mem_we ever asserted.
- Clean read miss, WORDS_PER_LINE=4, mem_ack held at 1 -> stall high 5 cycles; line_load on word_idx 0,1,2,3; set_valid+clr_dirty on beat 3; RESUME has stall=0, set_dirty=0; miss_count=1.
- Dirty write miss, mem_ack every other cycle -> WRITEBACK beats 0-3 with wb_sel=1, then REFILL beats 0-3, then RESUME with set_dirty=1. Total stall = 16 cycles + 1.
- WRITE_ALLOCATE=0, write miss with dirty=1 -> WRITE_AROUND only, mem_we=1, wb_sel=0, no WRITEBACK. On mem_ack stall=0 that cycle, then IDLE; no line_load.
- RST asserted during REFILL at cnt=2 -> next cycle IDLE, cnt=0, counters=0, set_valid never pulsed.
- Saturation: preload hit_count near max (PERF_W=4 override), 20 hits -> holds at 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and policy constants for the data-cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WRITEBACK    = 3'd1,
    REFILL       = 3'd2,
    RESUME       = 3'd3,
    WRITE_AROUND = 3'd4
  } cache_state_t;

  // Write-miss policy selectors for WRITE_ALLOCATE.
  localparam int ALLOC    = 1;
  localparam int NO_ALLOC = 0;

endpackage

// File: rtl/burst_counter.sv
// Word index for write-back / refill bursts; wraps modulo the line length.
module burst_counter #(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(WORDS_PER_LINE - 1));

  // Clear wins over increment; the power-of-two line length makes the
  // natural overflow return the index to 0 after the last beat.
  always_ff @(posedge CLK) begin
    if (RST || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Data-cache control FSM: hit/miss decision, write-back and refill burst
// sequencing over a per-word ack handshake, and hit/miss perf counters.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = $clog2(WORDS_PER_LINE),
  parameter int WRITE_ALLOCATE = ALLOC,
  parameter int PERF_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              hit,
  input  logic              dirty,
  input  logic              mem_ack,
  output logic              stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic              wb_sel,
  output logic [CNT_W-1:0]  word_idx,
  output logic              line_load,
  output logic              set_valid,
  output logic              set_dirty,
  output logic              clr_dirty,
  output logic [PERF_W-1:0] hit_count,
  output logic [PERF_W-1:0] miss_count
);

  cache_state_t     state, state_nxt;
  logic             op_wr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last, cnt_inc;
  logic             hit_ev, miss_ev;
  logic             req_any;

  assign req_any  = req_read | req_write;
  assign word_idx = cnt;

  burst_counter #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .CNT_W          (CNT_W)
  ) u_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (cnt_inc),
    .clr  (miss_ev),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // State register and latched request type (captured at miss detection).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      op_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (miss_ev) op_wr <= req_write;
    end
  end

  // Next-state and control decode; requests are only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    wb_sel    = 1'b0;
    line_load = 1'b0;
    set_valid = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    cnt_inc   = 1'b0;
    hit_ev    = 1'b0;
    miss_ev   = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (hit) begin
            set_dirty = req_write;
            hit_ev    = 1'b1;
          end else begin
            stall   = 1'b1;
            miss_ev = 1'b1;
            if (req_write && WRITE_ALLOCATE == NO_ALLOC) state_nxt = WRITE_AROUND;
            else if (dirty)                               state_nxt = WRITEBACK;
            else                                          state_nxt = REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall  = 1'b1;
        mem_we = 1'b1;
        wb_sel = 1'b1;
        if (mem_ack) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_nxt = REFILL;
        end
      end
      REFILL: begin
        stall  = 1'b1;
        mem_re = 1'b1;
        if (mem_ack) begin
          line_load = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            set_valid = 1'b1;
            clr_dirty = 1'b1;
            state_nxt = RESUME;
          end
        end
      end
      RESUME: begin
        // Pipeline retires the request against the freshly filled line.
        set_dirty = op_wr;
        state_nxt = IDLE;
      end
      WRITE_AROUND: begin
        mem_we = 1'b1;
        stall  = ~mem_ack;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_ev  && hit_count  != '1) hit_count  <= hit_count  + PERF_W'(1);
      if (miss_ev && miss_count != '1) miss_count <= miss_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: two instances (write-allocate / 32-bit counters
// and write-around / 4-bit counters) driven by the same stimulus, each
// checked every cycle against a beat-queue reference model.
module tb_cache_ctrl_fsm;

  localparam int N = 4;

  localparam int K_WB  = 0;
  localparam int K_RF  = 1;
  localparam int K_RES = 2;
  localparam int K_WA  = 3;

  typedef struct {
    int kind;
    int idx;
    bit wr;
  } beat_t;

  logic CLK = 1'b0;
  logic RST;
  logic req_read, req_write, hit, dirty, mem_ack;

  logic       stall [2];
  logic       mem_re [2];
  logic       mem_we [2];
  logic       wb_sel [2];
  logic [1:0] word_idx [2];
  logic       line_load [2];
  logic       set_valid [2];
  logic       set_dirty [2];
  logic       clr_dirty [2];
  logic [31:0] hit_count0, miss_count0;
  logic [3:0]  hit_count1, miss_count1;

  always #5 CLK = ~CLK;

  cache_ctrl_fsm #(.WORDS_PER_LINE(N), .WRITE_ALLOCATE(1), .PERF_W(32)) dut0 (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write),
    .hit(hit), .dirty(dirty), .mem_ack(mem_ack),
    .stall(stall[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]), .wb_sel(wb_sel[0]),
    .word_idx(word_idx[0]), .line_load(line_load[0]), .set_valid(set_valid[0]),
    .set_dirty(set_dirty[0]), .clr_dirty(clr_dirty[0]),
    .hit_count(hit_count0), .miss_count(miss_count0));

  cache_ctrl_fsm #(.WORDS_PER_LINE(N), .WRITE_ALLOCATE(0), .PERF_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write),
    .hit(hit), .dirty(dirty), .mem_ack(mem_ack),
    .stall(stall[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]), .wb_sel(wb_sel[1]),
    .word_idx(word_idx[1]), .line_load(line_load[1]), .set_valid(set_valid[1]),
    .set_dirty(set_dirty[1]), .clr_dirty(clr_dirty[1]),
    .hit_count(hit_count1), .miss_count(miss_count1));

  // Reference model: pending memory beats per instance plus counter values.
  beat_t       q [2][$];
  int unsigned hits [2];
  int unsigned misses [2];
  int unsigned cmax [2] = '{32'hFFFF_FFFF, 32'd15};
  bit          alloc [2] = '{1'b1, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;
  int stall_run [2];
  bit sv_seen [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_ctl(input int i);
    return {stall[i], mem_re[i], mem_we[i], wb_sel[i], word_idx[i],
            line_load[i], set_valid[i], set_dirty[i], clr_dirty[i]};
  endfunction

  // Expected control outputs for this cycle, from the head beat or the request.
  function automatic logic [9:0] exp_ctl(input int i);
    logic st = 0, re = 0, we = 0, wb = 0, ll = 0, sv = 0, sd = 0, cd = 0;
    logic [1:0] wi = 2'd0;
    beat_t b;
    if (q[i].size() == 0) begin
      if (req_read || req_write) begin
        if (hit) sd = req_write;
        else     st = 1'b1;
      end
    end else begin
      b = q[i][0];
      case (b.kind)
        K_WB: begin st = 1; we = 1; wb = 1; wi = 2'(b.idx); end
        K_RF: begin
          st = 1; re = 1; wi = 2'(b.idx);
          if (mem_ack) begin
            ll = 1;
            if (b.idx == N - 1) begin sv = 1; cd = 1; end
          end
        end
        K_RES: sd = b.wr;
        default: begin we = 1; st = ~mem_ack; end
      endcase
    end
    return {st, re, we, wb, wi, ll, sv, sd, cd};
  endfunction

  task automatic adv(input int i);
    if (RST) begin
      q[i].delete();
      hits[i]   = 0;
      misses[i] = 0;
      return;
    end
    if (q[i].size() == 0) begin
      if (req_read || req_write) begin
        if (hit) begin
          if (hits[i] != cmax[i]) hits[i]++;
        end else begin
          if (misses[i] != cmax[i]) misses[i]++;
          if (req_write && !alloc[i]) q[i].push_back('{K_WA, 0, 1'b1});
          else begin
            if (dirty) for (int w = 0; w < N; w++) q[i].push_back('{K_WB, w, 1'b0});
            for (int w = 0; w < N; w++) q[i].push_back('{K_RF, w, 1'b0});
            q[i].push_back('{K_RES, 0, req_write});
          end
        end
      end
    end else if (q[i][0].kind == K_RES || mem_ack) begin
      void'(q[i].pop_front());
    end
  endtask

  // One clock: compare everything, advance the model, move past the edge.
  task automatic cycle();
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ctl%0d", i), 32'(obs_ctl(i)), 32'(exp_ctl(i)));
      if (stall[i])     stall_run[i]++;
      if (set_valid[i]) sv_seen[i] = 1'b1;
    end
    chk("hit0",  hit_count0,       hits[0]);
    chk("miss0", miss_count0,      misses[0]);
    chk("hit1",  32'(hit_count1),  hits[1]);
    chk("miss1", 32'(miss_count1), misses[1]);
    for (int i = 0; i < 2; i++) adv(i);
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      stall_run[i] = 0;
      sv_seen[i]   = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input bit toggle_ack);
    for (int k = 0; k < 60 && (q[0].size() != 0 || q[1].size() != 0); k++) begin
      if (toggle_ack) mem_ack = ~mem_ack;
      cycle();
    end
    chk(tag, 32'(q[0].size() + q[1].size()), 32'd0);
  endtask

  initial begin
    RST = 1; req_read = 0; req_write = 0; hit = 0; dirty = 0; mem_ack = 0;
    @(posedge CLK); #1;
    cycle();
    cycle();
    RST = 0;
    cycle();
    chk("rst_hit0",  hit_count0,  32'd0);
    chk("rst_miss0", miss_count0, 32'd0);

    // Read hit: no stall, counted.
    req_read = 1; hit = 1;
    cycle();
    req_read = 0; hit = 0;
    cycle();
    chk("rdhit_cnt", hit_count0, 32'd1);

    // Clean read miss, ack every cycle: N+1 stall cycles on both instances.
    clr_stats();
    req_read = 1; mem_ack = 1;
    cycle();
    req_read = 0;
    drain("clean_drain", 1'b0);
    chk("clean_stall0", 32'(stall_run[0]), N + 1);
    chk("clean_stall1", 32'(stall_run[1]), N + 1);
    chk("clean_sv0",    32'(sv_seen[0]),  32'd1);

    // Dirty write miss, ack every other cycle: dut0 writes back then refills,
    // dut1 goes around the cache (one ack-less cycle, then ack).
    clr_stats();
    req_write = 1; dirty = 1; mem_ack = 1;
    cycle();
    req_write = 0; dirty = 0;
    drain("dirty_drain", 1'b1);
    chk("dirty_stall0", 32'(stall_run[0]), 4 * N + 1);
    chk("wa_stall1",    32'(stall_run[1]), 32'd2);
    chk("wa_sv1",       32'(sv_seen[1]),  32'd0);

    // Dirty write miss with immediate ack: write-around stalls one cycle.
    clr_stats();
    req_write = 1; dirty = 1; mem_ack = 1;
    cycle();
    req_write = 0; dirty = 0;
    drain("wa_drain", 1'b0);
    chk("wa_fast_stall1", 32'(stall_run[1]), 32'd1);
    chk("dirty_fast_stall0", 32'(stall_run[0]), 2 * N + 1);

    // Reset in the middle of a refill (word 2): no valid line, counters clear.
    clr_stats();
    req_read = 1; mem_ack = 1;
    cycle();
    req_read = 0;
    cycle();
    cycle();
    RST = 1;
    cycle();
    RST = 0; mem_ack = 0;
    cycle();
    cycle();
    chk("midrst_sv0",   32'(sv_seen[0]), 32'd0);
    chk("midrst_sv1",   32'(sv_seen[1]), 32'd0);
    chk("midrst_hit0",  hit_count0,      32'd0);
    chk("midrst_miss0", miss_count0,     32'd0);

    // Saturation: 20 hits on the 4-bit counter instance holds at 15.
    req_read = 1; hit = 1;
    for (int k = 0; k < 20; k++) cycle();
    req_read = 0; hit = 0;
    cycle();
    chk("sat_hit1", 32'(hit_count1), 32'd15);
    chk("sat_hit0", hit_count0,      32'd20);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      RST       = ($urandom_range(0, 63) == 0);
      req_read  = 1'($urandom);
      req_write = 1'($urandom);
      hit       = 1'($urandom);
      dirty     = 1'($urandom);
      mem_ack   = ($urandom_range(0, 9) < 7);
      cycle();
    end
    RST = 0; req_read = 0; req_write = 0; mem_ack = 1;
    drain("rand_drain", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
